// File: rtl/host32_bridge.sv
// host32_bridge: splits 32-bit longword requests into big-endian 16-bit SDRAM host cycles with ack timeout
module host32_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        sysclk,
  input  logic        reset_in,
  input  logic        s_cs,
  input  logic        s_we,
  input  logic [21:0] s_adr,
  input  logic [3:0]  s_sel,
  input  logic [31:0] s_dat_w,
  output logic [31:0] s_dat_r,
  output logic        s_ack,
  output logic        s_err,
  output logic        host_cs,
  output logic [23:0] host_adr,
  output logic        host_we,
  output logic [1:0]  host_bs,
  output logic [15:0] host_wdat,
  input  logic [15:0] host_rdat,
  input  logic        host_ack
);
  typedef enum logic [2:0] {IDLE, HI, GAP, LO, DONE, REL} state_t;
  state_t      r_state, w_next;
  logic        r_we;
  logic [21:0] r_adr;
  logic [3:0]  r_sel;
  logic [31:0] r_dat_w;
  logic [15:0] r_cnt;
  logic        w_idle, w_busy, w_to, w_go, w_lo, w_we;
  logic [21:0] w_adr;
  logic [3:0]  w_sel;
  logic [31:0] w_dat_w;
  // state register
  always_ff @(posedge sysclk or negedge reset_in)
    if (!reset_in) r_state <= IDLE;
    else r_state <= w_next;
  // next state; an empty request lingers in DONE until its ack has been issued
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (s_cs) w_next = |s_sel[3:2] ? HI : |s_sel[1:0] ? LO : DONE;
      HI: w_next = host_ack ? (|r_sel[1:0] ? GAP : DONE) : w_to ? REL : HI;
      GAP: w_next = LO;
      LO: w_next = host_ack ? DONE : w_to ? REL : LO;
      DONE: w_next = s_ack ? REL : DONE;
      REL: if (!s_cs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // output decode; in IDLE the live request is used so the first host cycle starts on accept
  always_comb begin
    w_idle  = r_state == IDLE;
    w_busy  = r_state == HI || r_state == LO;
    w_to    = w_busy && !host_ack && r_cnt == 16'(TIMEOUT - 1);
    w_go    = w_next == HI || w_next == LO;
    w_lo    = w_next == LO;
    w_we    = w_idle ? s_we : r_we;
    w_adr   = w_idle ? s_adr : r_adr;
    w_sel   = w_idle ? s_sel : r_sel;
    w_dat_w = w_idle ? s_dat_w : r_dat_w;
  end
  // request latch and per-half ack timeout counter
  always_ff @(posedge sysclk or negedge reset_in)
    if (!reset_in) begin
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat_w <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_idle && s_cs) begin
        r_we    <= s_we;
        r_adr   <= s_adr;
        r_sel   <= s_sel;
        r_dat_w <= s_dat_w;
      end
      r_cnt <= (w_busy && !host_ack) ? r_cnt + 16'd1 : 16'd0;
    end
  // registered outputs and read data capture
  always_ff @(posedge sysclk or negedge reset_in)
    if (!reset_in) begin
      host_cs   <= 1'b0;
      host_adr  <= '0;
      host_we   <= 1'b0;
      host_bs   <= '0;
      host_wdat <= '0;
      s_ack     <= 1'b0;
      s_err     <= 1'b0;
      s_dat_r   <= '0;
    end else begin
      host_cs <= w_go;
      s_ack   <= w_next == DONE && !w_idle;
      s_err   <= w_to;
      if (w_go) begin
        host_adr  <= {w_adr, w_lo, 1'b0};
        host_bs   <= w_lo ? w_sel[1:0] : w_sel[3:2];
        host_wdat <= w_lo ? w_dat_w[15:0] : w_dat_w[31:16];
        host_we   <= w_we;
      end
      if (w_idle && s_cs) s_dat_r <= '0;
      else if (r_state == HI && host_ack && !r_we) s_dat_r[31:16] <= host_rdat;
      else if (r_state == LO && host_ack && !r_we) s_dat_r[15:0] <= host_rdat;
    end
endmodule

// File: tb/tb_host32_bridge.sv
// tb_host32_bridge: directed and random longword transactions checked against a half-splitting reference model
module tb_host32_bridge;
  localparam int TO = 8;
  logic        sysclk = 0, reset_in = 0, s_cs = 0, s_we = 0;
  logic [21:0] s_adr = 0;
  logic [3:0]  s_sel = 0;
  logic [31:0] s_dat_w = 0;
  logic [31:0] s_dat_r;
  logic        s_ack, s_err, host_cs, host_we;
  logic [23:0] host_adr;
  logic [1:0]  host_bs;
  logic [15:0] host_wdat;
  logic [15:0] host_rdat = 0;
  logic        host_ack = 0;
  int n_vec = 0, n_miss = 0;

  host32_bridge #(.TIMEOUT(TO)) dut (
    .sysclk(sysclk), .reset_in(reset_in), .s_cs(s_cs), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .host_cs(host_cs), .host_adr(host_adr), .host_we(host_we), .host_bs(host_bs),
    .host_wdat(host_wdat), .host_rdat(host_rdat), .host_ack(host_ack)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  // One master transaction with a cycle-by-cycle host responder; hold = extra cycles s_cs stays high after completion
  task automatic txn(input logic we, input logic [21:0] adr, input logic [3:0] sel, input logic [31:0] wd,
                     input logic [31:0] rd, input int dly_hi, input int dly_lo, input bit noack, input int hold);
    logic [23:0] e_adr [2];
    logic [1:0]  e_bs [2];
    logic [15:0] e_wd [2];
    logic [15:0] e_rd [2];
    int          e_dly [2];
    int          n_half = 0;
    logic [31:0] e_dat = 0;
    logic [42:0] snap = 0;
    int          half = 0, hlen = 0, fall = 0, done_cyc = 0;
    logic        prev = 0;
    if (sel[3:2] != 0) begin
      e_adr[n_half] = {adr, 2'b00}; e_bs[n_half] = sel[3:2]; e_wd[n_half] = wd[31:16];
      e_rd[n_half] = rd[31:16]; e_dly[n_half] = dly_hi; n_half++;
    end
    if (sel[1:0] != 0) begin
      e_adr[n_half] = {adr, 2'b10}; e_bs[n_half] = sel[1:0]; e_wd[n_half] = wd[15:0];
      e_rd[n_half] = rd[15:0]; e_dly[n_half] = dly_lo; n_half++;
    end
    if (!we && !noack) e_dat = {sel[3:2] != 0 ? rd[31:16] : 16'h0, sel[1:0] != 0 ? rd[15:0] : 16'h0};
    s_cs = 1; s_we = we; s_adr = adr; s_sel = sel; s_dat_w = wd;
    for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
      tick();
      if (host_cs) begin
        if (!prev) begin
          if (half < n_half) begin
            chk("host_adr", host_adr, e_adr[half]);
            chk("host_bs", host_bs, e_bs[half]);
            chk("host_we", host_we, we);
            chk("host_wdat", host_wdat, e_wd[half]);
            chk(half == 0 ? "first_rise" : "gap_len", c, half == 0 ? 1 : fall + 1);
          end else chk("extra_half", half + 1, n_half);
          snap = {host_we, host_bs, host_adr, host_wdat};
          hlen = 0;
        end else chk("stable", {host_we, host_bs, host_adr, host_wdat}, snap);
        host_ack = !noack && half < n_half && hlen == e_dly[half];
        host_rdat = host_ack ? e_rd[half] : 16'($urandom);
        hlen++;
      end else begin
        host_ack = 0;
        host_rdat = 16'($urandom);
        if (prev) begin
          fall = c;
          half++;
          if (noack) chk("cs_high_len", hlen, TO);
        end
      end
      if (s_ack || s_err) done_cyc = c;
      prev = host_cs;
    end
    host_ack = 0;
    chk("responded", 32'(done_cyc != 0), 1);
    chk("s_ack", s_ack, !noack);
    chk("s_err", s_err, noack);
    chk("s_dat_r", s_dat_r, e_dat);
    chk("halves", half, noack ? 1 : n_half);
    chk(n_half == 0 ? "empty_lat" : "done_lat", done_cyc, n_half == 0 ? 2 : fall);
    for (int i = 0; i <= hold; i++) begin
      tick();
      chk("quiet", {host_cs, s_ack, s_err}, 0);
    end
    s_cs = 0;
    tick();
    chk("held_dat", s_dat_r, e_dat);
  endtask

  initial begin
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_outs", {host_cs, host_we, host_bs, host_adr, host_wdat, s_ack, s_err}, 0);
    chk("rst_dat", s_dat_r, 0);
    @(negedge sysclk) reset_in = 1;
    tick();
    txn(1, 22'h000010, 4'b1111, 32'h01234567, 0, 3, 3, 0, 0);
    txn(0, 22'h0ABCDE, 4'b1100, 0, 32'hBEEF0000, 2, 0, 0, 0);
    txn(0, 22'h155555, 4'b0001, 0, 32'h000000A5, 0, 1, 0, 0);
    txn(0, 22'h000123, 4'b0000, 0, 0, 0, 0, 0, 1);
    txn(0, 22'h3FFFFF, 4'b1111, 0, 32'hCAFED00D, 0, 0, 0, 0);
    txn(1, 22'h000200, 4'b1010, 32'h89ABCDEF, 0, 7, 7, 0, 0);
    txn(0, 22'h000300, 4'b1111, 0, 32'h12345678, 0, 0, 1, 0);
    txn(1, 22'h000301, 4'b0011, 32'h11112222, 0, 0, 0, 1, 2);
    txn(0, 22'h000400, 4'b0110, 0, 32'h5A5AA5A5, 1, 4, 0, 5);
    for (int k = 0; k < 25; k++)
      txn(1'($urandom), 22'($urandom), 4'($urandom), $urandom, $urandom,
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5) == 0, $urandom_range(0, 3));
    s_cs = 1; s_we = 0; s_adr = 22'h00ABCD; s_sel = 4'hF;
    tick();
    chk("pre_rst_cs", host_cs, 1);
    tick();
    #2 reset_in = 0;
    #1;
    chk("mid_rst_outs", {host_cs, host_we, host_bs, host_adr, host_wdat, s_ack, s_err}, 0);
    chk("mid_rst_dat", s_dat_r, 0);
    s_cs = 0;
    @(negedge sysclk) reset_in = 1;
    tick();
    chk("post_rst_idle", {host_cs, s_ack, s_err}, 0);
    txn(0, 22'h00ABCD, 4'b1111, 0, 32'hFACEB00C, 1, 2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
